// File: rtl/mimo_pkg.sv
// Shared constants and state encoding for the MIMO detector front-end sequencer.
package mimo_pkg;
    localparam int WL      = 15;
    localparam int H_BEATS = 8;
    localparam int Y_BEATS = 2;
    localparam int SYM_W   = 16;

    localparam logic [2:0] H_LAST = 3'(H_BEATS - 1);
    localparam logic [2:0] Y_LAST = 3'(Y_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_H,
        LOAD_Y,
        ISSUE
    } state_t;
endpackage

// File: rtl/mimo_latency_tracker.sv
// Delay line that follows detector loads through the fixed detector latency.
module mimo_latency_tracker #(
    parameter int DET_LAT = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic capture_o
);
    logic [DET_LAT-1:0] pipe;

    // One flop per cycle of latency, so up to DET_LAT loads can be in flight.
    for (genvar gi = 0; gi < DET_LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            always_ff @(posedge clk or posedge rst) begin
                if (rst) pipe[gi] <= 1'b0;
                else     pipe[gi] <= load_i;
            end
        end else begin : g_body
            always_ff @(posedge clk or posedge rst) begin
                if (rst) pipe[gi] <= 1'b0;
                else     pipe[gi] <= pipe[gi-1];
            end
        end
    end

    assign capture_o = pipe[DET_LAT-1];
endmodule

// File: rtl/mimo_frame_sequencer.sv
// Frames the sample stream into H/Y staging-buffer writes, issues detector loads
// and re-times detector results with a valid strobe.
module mimo_frame_sequencer
    import mimo_pkg::*;
#(
    parameter int WL      = mimo_pkg::WL,
    parameter int DET_LAT = 12,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [4*WL-1:0]   in_data_i,
    input  logic              in_sof_i,
    input  logic              in_hold_h_i,
    output logic              buf_we_o,
    output logic              buf_sel_o,
    output logic [2:0]        buf_idx_o,
    output logic [4*WL-1:0]   buf_wdata_o,
    output logic              det_load_o,
    input  logic [SYM_W-1:0]  det_x_i,
    output logic [SYM_W-1:0]  x_o,
    output logic              x_valid_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  frames_o
);
    state_t             state;
    logic [2:0]         idx;
    logic               h_valid;
    logic               ready_reg;
    logic               err_reg;
    logic               load_reg;
    logic               x_valid_reg;
    logic [SYM_W-1:0]   x_reg;
    logic [CNT_W-1:0]   frames_reg;
    logic               capture;

    logic accept, mid_frame, start_h, start_y, drop, last_y, we;

    assign accept    = in_valid_i & ready_reg;
    assign mid_frame = (state == LOAD_H) || (state == LOAD_Y);
    assign start_h   = accept & in_sof_i & ~in_hold_h_i;
    assign start_y   = accept & in_sof_i & in_hold_h_i & h_valid;
    // A hold frame with no stored H, or a stray continuation beat, is discarded.
    assign drop      = accept & ((in_sof_i & in_hold_h_i & ~h_valid) |
                                 (~in_sof_i & (state == IDLE)));
    assign last_y    = accept & ~in_sof_i & (state == LOAD_Y) & (idx == Y_LAST);
    assign we        = accept & ~drop;

    always_comb begin
        buf_sel_o = 1'b0;
        buf_idx_o = 3'd0;
        if (we) begin
            if (in_sof_i) begin
                buf_sel_o = in_hold_h_i;
                buf_idx_o = 3'd0;
            end else begin
                buf_sel_o = (state == LOAD_Y);
                buf_idx_o = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 3'd0;
            h_valid     <= 1'b0;
            ready_reg   <= 1'b0;
            err_reg     <= 1'b0;
            load_reg    <= 1'b0;
            x_valid_reg <= 1'b0;
            x_reg       <= '0;
            frames_reg  <= '0;
        end else begin
            err_reg     <= drop | (accept & in_sof_i & mid_frame);
            load_reg    <= last_y;
            ready_reg   <= ~last_y;
            x_valid_reg <= capture;
            if (capture) x_reg <= det_x_i;

            // Any accepted sof restarts framing, even in the middle of a frame.
            if (start_h) begin
                state   <= LOAD_H;
                idx     <= 3'd1;
                h_valid <= 1'b0;
            end else if (start_y) begin
                state <= LOAD_Y;
                idx   <= 3'd1;
            end else if (accept & in_sof_i) begin
                state <= IDLE;
                idx   <= 3'd0;
            end else begin
                case (state)
                    LOAD_H: if (accept) begin
                        if (idx == H_LAST) begin
                            h_valid <= 1'b1;
                            state   <= LOAD_Y;
                            idx     <= 3'd0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                    LOAD_Y: if (accept) begin
                        if (idx == Y_LAST) begin
                            state <= ISSUE;
                            idx   <= 3'd0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                    ISSUE: begin
                        frames_reg <= frames_reg + CNT_W'(1);
                        state      <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    mimo_latency_tracker #(
        .DET_LAT (DET_LAT)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load_reg),
        .capture_o (capture)
    );

    assign in_ready_o  = ready_reg;
    assign buf_we_o    = we;
    assign buf_wdata_o = in_data_i;
    assign det_load_o  = load_reg;
    assign x_o         = x_reg;
    assign x_valid_o   = x_valid_reg;
    assign err_o       = err_reg;
    assign frames_o    = frames_reg;
endmodule

// File: tb/tb_mimo_frame_sequencer.sv
// Scoreboard bench for mimo_frame_sequencer: expected writes, loads, errors and
// detected vectors are queued as beats are driven and matched as the DUT emits them.
module tb_mimo_frame_sequencer;
    localparam int WL      = 15;
    localparam int DET_LAT = 12;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [4*WL-1:0]   in_data_i = '0;
    logic              in_sof_i = 1'b0;
    logic              in_hold_h_i = 1'b0;
    logic              buf_we_o;
    logic              buf_sel_o;
    logic [2:0]        buf_idx_o;
    logic [4*WL-1:0]   buf_wdata_o;
    logic              det_load_o;
    logic [15:0]       det_x_i;
    logic [15:0]       x_o;
    logic              x_valid_o;
    logic              err_o;
    logic [CNT_W-1:0]  frames_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_frames = 0;

    logic [63:0] wq[$];
    int          loadq[$];
    int          errq[$];
    int          xcq[$];
    logic [15:0] xvq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] det_val(input int c);
        return 16'hA5C3 ^ 16'(c * 37);
    endfunction

    assign det_x_i = det_val(cyc);

    mimo_frame_sequencer #(
        .WL      (WL),
        .DET_LAT (DET_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_sof_i    (in_sof_i),
        .in_hold_h_i (in_hold_h_i),
        .buf_we_o    (buf_we_o),
        .buf_sel_o   (buf_sel_o),
        .buf_idx_o   (buf_idx_o),
        .buf_wdata_o (buf_wdata_o),
        .det_load_o  (det_load_o),
        .det_x_i     (det_x_i),
        .x_o         (x_o),
        .x_valid_o   (x_valid_o),
        .err_o       (err_o),
        .frames_o    (frames_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every DUT event must match the head of its queue.
    always @(negedge clk) begin
        if (buf_we_o) begin
            if (wq.size() == 0) check("wr_unexpected", 64'(1), 64'(0));
            else begin
                logic [63:0] e;
                e = wq.pop_front();
                $display("write sel=%0d idx=%0d cycle=%0d", buf_sel_o, buf_idx_o, cyc);
                check("wr_beat", {buf_sel_o, buf_idx_o, buf_wdata_o}, e);
            end
        end
        if (det_load_o) begin
            if (loadq.size() == 0) check("load_unexpected", 64'(1), 64'(0));
            else begin
                int e;
                e = loadq.pop_front();
                $display("load cycle=%0d", cyc);
                check("load_cycle", 64'(cyc), 64'(e));
            end
        end
        if (err_o) begin
            if (errq.size() == 0) check("err_unexpected", 64'(1), 64'(0));
            else begin
                int e;
                e = errq.pop_front();
                $display("err cycle=%0d", cyc);
                check("err_cycle", 64'(cyc), 64'(e));
            end
        end
        if (x_valid_o) begin
            if (xcq.size() == 0) check("x_unexpected", 64'(1), 64'(0));
            else begin
                int ec;
                logic [15:0] ev;
                ec = xcq.pop_front();
                ev = xvq.pop_front();
                $display("x_valid x=%h cycle=%0d", x_o, cyc);
                check("x_cycle", 64'(cyc), 64'(ec));
                check("x_data", 64'(x_o), 64'(ev));
            end
        end
    end

    // Drive one beat; called with time just past a rising edge.
    task automatic send_beat(input bit sof, input bit hold, input bit we_exp,
                             input bit sel_exp, input int idx_exp,
                             input bit err_exp, input bit last_exp);
        logic [4*WL-1:0] d;
        int n;
        int acc;
        d = 60'({$urandom(), $urandom()});
        in_valid_i  = 1'b1;
        in_sof_i    = sof;
        in_hold_h_i = hold;
        in_data_i   = d;
        if (we_exp) wq.push_back({sel_exp, 3'(idx_exp), d});
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready_o) break;
            n++;
            if (n > 40) begin
                check("ready_timeout", 64'(0), 64'(1));
                break;
            end
        end
        acc = cyc;
        if (err_exp) errq.push_back(acc + 1);
        if (last_exp) begin
            loadq.push_back(acc + 1);
            xcq.push_back(acc + DET_LAT + 2);
            xvq.push_back(det_val(acc + 1 + DET_LAT));
            exp_frames++;
        end
        @(posedge clk);
        #1;
        in_valid_i  = 1'b0;
        in_sof_i    = 1'b0;
        in_hold_h_i = 1'b0;
    endtask

    task automatic full_frame(input bit abort_err);
        send_beat(1'b1, 1'b0, 1'b1, 1'b0, 0, abort_err, 1'b0);
        for (int i = 1; i < 8; i++) send_beat(1'b0, 1'b0, 1'b1, 1'b0, i, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1);
    endtask

    task automatic hold_frame();
        send_beat(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1);
    endtask

    task automatic partial_h(input int n);
        for (int i = 0; i < n; i++) send_beat(i == 0, 1'b0, 1'b1, 1'b0, i, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  64'(in_ready_o), 64'(0));
        check({tag, "_we"},     64'(buf_we_o),   64'(0));
        check({tag, "_load"},   64'(det_load_o), 64'(0));
        check({tag, "_x"},      64'(x_o),        64'(0));
        check({tag, "_xvalid"}, 64'(x_valid_o),  64'(0));
        check({tag, "_err"},    64'(err_o),      64'(0));
        check({tag, "_frames"}, 64'(frames_o),   64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        xcq.delete();
        xvq.delete();
        exp_frames = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
    endtask

    initial begin
        #1;
        check_all_zero("por");
        idle(2);
        rst = 1'b0;
        idle(2);

        // Full frame, contiguous beats
        full_frame(1'b0);
        idle(3);
        check("frames_full", 64'(frames_o), 64'(exp_frames));
        idle(DET_LAT + 2);

        // Hold frame reuses stored H
        hold_frame();
        idle(3);
        check("frames_hold", 64'(frames_o), 64'(exp_frames));
        idle(DET_LAT + 2);

        // Hold sof with no stored H after reset is dropped
        do_reset();
        send_beat(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        idle(3);
        check("frames_drop", 64'(frames_o), 64'(0));

        // Abort at H5 by a new sof, then restart from H0
        partial_h(5);
        full_frame(1'b1);
        idle(DET_LAT + 3);

        // H bank invalidated by a new frame: hold sof mid-H is dropped
        partial_h(3);
        send_beat(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        send_beat(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        send_beat(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        idle(2);
        check("frames_after_abort", 64'(frames_o), 64'(exp_frames));

        // Restore H, then four hold frames back to back
        full_frame(1'b0);
        for (int i = 0; i < 4; i++) hold_frame();
        idle(DET_LAT + 4);
        check("frames_b2b", 64'(frames_o), 64'(exp_frames));

        // Reset with two loads in flight
        hold_frame();
        hold_frame();
        idle(2);
        check("loads_fired", 64'(loadq.size()), 64'(0));
        do_reset();
        idle(DET_LAT + 10);
        check("frames_post_reset", 64'(frames_o), 64'(0));

        check("wq_left",   64'(wq.size()),    64'(0));
        check("load_left", 64'(loadq.size()), 64'(0));
        check("err_left",  64'(errq.size()),  64'(0));
        check("x_left",    64'(xcq.size()),   64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
